// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with active-low request/grant, hold-while-requesting and park-on-last-owner.
// Define BUS_ARB_TENURE_EN to build the bounded-tenure counter, forced rotation and lock_ override.
module bus_arbiter_rr #(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_WIDTH   = 2,
    parameter int MAX_TENURE  = 16
) (
    input  logic                   clk,
    input  logic                   reset_,
    input  logic [NUM_MASTERS-1:0] req_,
    input  logic [NUM_MASTERS-1:0] lock_,
    output logic [NUM_MASTERS-1:0] grnt_,
    output logic [IDX_WIDTH-1:0]   owner,
    output logic [7:0]             tenure_cnt
);

    logic [IDX_WIDTH-1:0] owner_r;
    logic [IDX_WIDTH-1:0] next_owner_s;
    logic [IDX_WIDTH-1:0] cand_s;
    logic                 found_s;
    logic                 owner_req_s;
    logic                 expired_s;

    // Extract the current owner's request (active-high internally)
    always_comb begin
        owner_req_s = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            owner_req_s = owner_req_s | ((int'(owner_r) == i) & ~req_[i]);
        end
    end

    // Rotating search; walking downward leaves the nearest requester after owner in cand_s
    always_comb begin
        int idx_v;
        cand_s  = owner_r;
        found_s = 1'b0;
        idx_v   = 0;
        for (int k = NUM_MASTERS - 1; k >= 1; k--) begin
            idx_v   = int'(owner_r) + k;
            idx_v   = (idx_v >= NUM_MASTERS) ? idx_v - NUM_MASTERS : idx_v;
            cand_s  = (!req_[idx_v]) ? IDX_WIDTH'(idx_v) : cand_s;
            found_s = found_s | ~req_[idx_v];
        end
    end

    // Next-owner priority: hold, then rotate to a waiting master, else park
    always_comb begin
        next_owner_s = owner_r;
        if (owner_req_s && !expired_s) begin
            next_owner_s = owner_r;
        end else if (found_s) begin
            next_owner_s = cand_s;
        end else begin
            next_owner_s = owner_r;
        end
    end

    // Owner register
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            owner_r <= {IDX_WIDTH{1'b0}};
        end else begin
            owner_r <= next_owner_s;
        end
    end

`ifdef BUS_ARB_TENURE_EN
    logic [7:0] cnt_r;
    logic [7:0] next_cnt_s;
    logic       owner_lock_s;

    // Extract the current owner's lock (active-high internally); other masters' locks are ignored
    always_comb begin
        owner_lock_s = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            owner_lock_s = owner_lock_s | ((int'(owner_r) == i) & ~lock_[i]);
        end
    end

    assign expired_s = (cnt_r == 8'(MAX_TENURE - 1)) && owner_req_s && !owner_lock_s && found_s;

    // Tenure count: restarts on handoff or idle owner, otherwise saturating increment
    always_comb begin
        next_cnt_s = 8'd0;
        if ((next_owner_s != owner_r) || !owner_req_s) begin
            next_cnt_s = 8'd0;
        end else if (cnt_r == 8'(MAX_TENURE - 1)) begin
            next_cnt_s = cnt_r;
        end else begin
            next_cnt_s = cnt_r + 8'd1;
        end
    end

    // Tenure counter register
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            cnt_r <= 8'd0;
        end else begin
            cnt_r <= next_cnt_s;
        end
    end

    assign tenure_cnt = cnt_r;
`else
    logic unused_lock_s;
    assign unused_lock_s = ^lock_;
    assign expired_s     = 1'b0;
    assign tenure_cnt    = 8'd0;
`endif

    // One-hot-low grant decoded from the owner register
    always_comb begin
        grnt_ = {NUM_MASTERS{1'b1}};
        for (int i = 0; i < NUM_MASTERS; i++) begin
            grnt_[i] = (int'(owner_r) != i);
        end
    end

    assign owner = owner_r;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: a 4-master and a 3-master instance checked every cycle against a
// rule-level model, plus directed scenarios with literal expectations.
module tb_bus_arbiter_rr;

`ifdef BUS_ARB_TENURE_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif
    localparam int M = 4;

    logic       clk = 1'b0;
    logic       reset_;
    logic [3:0] req4  = 4'b1111;
    logic [3:0] lock4 = 4'b1111;
    logic [2:0] req3  = 3'b111;
    logic [2:0] lock3 = 3'b111;
    logic [3:0] grnt4;
    logic [2:0] grnt3;
    logic [1:0] own4;
    logic [1:0] own3;
    logic [7:0] cnt4;
    logic [7:0] cnt3;

    int tests = 0;
    int fails = 0;
    int m4_own = 0;
    int m4_cnt = 0;
    int m3_own = 0;
    int m3_cnt = 0;

    bus_arbiter_rr #(.NUM_MASTERS(4), .IDX_WIDTH(2), .MAX_TENURE(M)) u4 (
        .clk(clk), .reset_(reset_), .req_(req4), .lock_(lock4),
        .grnt_(grnt4), .owner(own4), .tenure_cnt(cnt4)
    );

    bus_arbiter_rr #(.NUM_MASTERS(3), .IDX_WIDTH(2), .MAX_TENURE(M)) u3 (
        .clk(clk), .reset_(reset_), .req_(req3), .lock_(lock3),
        .grnt_(grnt3), .owner(own3), .tenure_cnt(cnt3)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Next owner from the arbitration rules: list of waiting masters in rotation order
    function automatic int nxt_own(input int n, input logic [3:0] req, input logic [3:0] lock,
                                   input int own, input int cnt);
        int  waiting[$];
        bit  oreq;
        bit  expired;
        for (int k = 1; k < n; k++) begin
            if (!req[(own + k) % n]) waiting.push_back((own + k) % n);
        end
        oreq    = !req[own];
        expired = TEN && (cnt == M - 1) && oreq && lock[own] && (waiting.size() > 0);
        if (oreq && !expired) return own;
        if (waiting.size() > 0) return waiting[0];
        return own;
    endfunction

    function automatic int nxt_cnt(input int n, input logic [3:0] req, input logic [3:0] lock,
                                   input int own, input int cnt);
        int no;
        no = nxt_own(n, req, lock, own, cnt);
        if (!TEN || no != own || req[own]) return 0;
        return (cnt + 1 > M - 1) ? M - 1 : cnt + 1;
    endfunction

    function automatic int exp_grant(input int own, input int n);
        logic [3:0] g;
        g = 4'b1111;
        for (int i = 0; i < 4; i++) g[i] = (i != own);
        return (n == 3) ? int'(g[2:0]) : int'(g);
    endfunction

    // Reference model state
    always @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            m4_own <= 0; m4_cnt <= 0; m3_own <= 0; m3_cnt <= 0;
        end else begin
            m4_own <= nxt_own(4, req4, lock4, m4_own, m4_cnt);
            m4_cnt <= nxt_cnt(4, req4, lock4, m4_own, m4_cnt);
            m3_own <= nxt_own(3, {1'b1, req3}, {1'b1, lock3}, m3_own, m3_cnt);
            m3_cnt <= nxt_cnt(3, {1'b1, req3}, {1'b1, lock3}, m3_own, m3_cnt);
        end
    end

    // Per-cycle comparison on the falling edge
    always @(negedge clk) begin
        check("m4_owner", int'(own4), m4_own);
        check("m4_cnt", int'(cnt4), m4_cnt);
        check("m4_grant", int'(grnt4), exp_grant(m4_own, 4));
        check("m3_owner", int'(own3), m3_own);
        check("m3_cnt", int'(cnt3), m3_cnt);
        check("m3_grant", int'(grnt3), exp_grant(m3_own, 3));
        check("m3_owner_range", int'(own3 < 2'd3), 1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_ = 1'b1;
        #2 reset_ = 1'b0;
        step();
        step();
        reset_ = 1'b1;

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_owner", int'(own4), 0);
            check("idle_grant", int'(grnt4), 4'b1110);
            check("idle_cnt", int'(cnt4), 0);
        end

        // Wrap from owner 3 to master 0
        req4 = 4'b0111;
        step();
        check("rr_own3", int'(own4), 3);
        req4 = 4'b1010;
        step();
        check("rr_wrap_owner", int'(own4), 0);
        check("rr_wrap_grant", int'(grnt4), 4'b1110);

        // Tenure expiry: master 1 continuous, master 2 joins one cycle later
        req4 = 4'b1101;
        step();
        check("exp_owner_c0", int'(own4), 1);
        check("exp_cnt_c0", int'(cnt4), 0);
        req4 = 4'b1001;
        for (int i = 1; i < 4; i++) begin
            step();
            check("exp_grant1", int'(grnt4[1]), 0);
            check("exp_cnt", int'(cnt4), TEN ? i : 0);
        end
        step();
        check("exp_owner_after", int'(own4), TEN ? 2 : 1);
        check("exp_cnt_after", int'(cnt4), 0);

        // Lock override on owner 1
        req4 = 4'b1101;
        step();
        check("lock_setup_owner", int'(own4), 1);
        lock4 = 4'b1101;
        req4  = 4'b1001;
        for (int i = 0; i < 20; i++) begin
            step();
            check("lock_hold_owner", int'(own4), 1);
        end
        check("lock_cnt_sat", int'(cnt4), TEN ? 3 : 0);
        lock4 = 4'b1111;
        step();
        check("lock_release_owner", int'(own4), TEN ? 2 : 1);

        // Non-power-of-two wrap on the 3-master instance
        req3 = 3'b011;
        step();
        check("np2_owner2", int'(own3), 2);
        req3 = 3'b110;
        step();
        check("np2_wrap_owner", int'(own3), 0);
        check("np2_wrap_grant", int'(grnt3), 3'b110);

        // Random traffic, checked by the per-cycle model
        for (int i = 0; i < 1000; i++) begin
            req4  = 4'($urandom);
            lock4 = 4'($urandom);
            req3  = 3'($urandom);
            lock3 = 3'($urandom);
            step();
        end

        // Async reset mid-tenure at owner 1
        lock4 = 4'b1111;
        lock3 = 3'b111;
        req3  = 3'b111;
        req4  = 4'b1110;
        step();
        req4 = 4'b1101;
        step();
        check("ar_owner_c0", int'(own4), 1);
        step();
        step();
        check("ar_owner", int'(own4), 1);
        check("ar_cnt", int'(cnt4), TEN ? 2 : 0);
        #2 reset_ = 1'b0;
        #1;
        check("ar_reset_owner", int'(own4), 0);
        check("ar_reset_cnt", int'(cnt4), 0);
        check("ar_reset_grant", int'(grnt4), 4'b1110);
        step();
        reset_ = 1'b1;
        req4   = 4'b1111;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
